// File: rtl/rv_csr_arb_if.sv
// Request/response and CSR-file bus for rv_csr_arb.
// The master modport is the arbiter side; the slave modport is the threads plus CSR file.
interface rv_csr_arb_if #(
  parameter int NUM_THREADS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12
) ();
  logic [NUM_THREADS-1:0]            req;
  logic [2*NUM_THREADS-1:0]          req_op;
  logic [ADDR_WIDTH*NUM_THREADS-1:0] req_addr;
  logic [DATA_WIDTH*NUM_THREADS-1:0] req_wdata;
  logic [NUM_THREADS-1:0]            ack;
  logic [DATA_WIDTH-1:0]             rdata;
  logic                              busy;
  logic [ADDR_WIDTH-1:0]             csr_addr_out;
  logic [DATA_WIDTH-1:0]             csr_out;
  logic [ADDR_WIDTH-1:0]             csr_addr_in;
  logic [DATA_WIDTH-1:0]             csr_in;
  logic                              csr_wr;
  logic                              en;

  modport master (
    input  req, req_op, req_addr, req_wdata, csr_out,
    output ack, rdata, busy, csr_addr_out, csr_addr_in, csr_in, csr_wr, en
  );

  modport slave (
    output req, req_op, req_addr, req_wdata, csr_out,
    input  ack, rdata, busy, csr_addr_out, csr_addr_in, csr_in, csr_wr, en
  );
endinterface

// File: rtl/rv_csr_arb.sv
// Round-robin arbiter that serialises per-thread CSR read-modify-write requests
// into a registered CSR read followed by a conditional write, returning the old value.
module rv_csr_arb #(
  parameter int NUM_THREADS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  rv_csr_arb_if.master bus
);

  localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [1:0]              op_q, op_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NUM_THREADS-1:0]  ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   caddr_rd_q, caddr_rd_d;
  logic [ADDR_WIDTH-1:0]   caddr_wr_q, caddr_wr_d;
  logic [DATA_WIDTH-1:0]   cwdata_q, cwdata_d;

  logic [NUM_THREADS-1:0]  elig;
  logic                    grant_vld;
  logic [IDX_W-1:0]        grant_idx;
  logic [DATA_WIDTH-1:0]   new_val;
  logic                    wr_ok;

  function automatic logic [DATA_WIDTH-1:0] rmw(input logic [1:0]            op,
                                                input logic [DATA_WIDTH-1:0] old,
                                                input logic [DATA_WIDTH-1:0] wd);
    case (op)
      2'b01:   rmw = wd;
      2'b10:   rmw = old | wd;
      2'b11:   rmw = old & ~wd;
      default: rmw = old;
    endcase
  endfunction

  // Read-only never writes; set/clear with an empty mask would rewrite the old value.
  function automatic logic write_allowed(input logic [1:0]            op,
                                         input logic [DATA_WIDTH-1:0] wd);
    write_allowed = (op != 2'b00) && !(op[1] && (wd == '0));
  endfunction

  // The thread being acked this cycle is masked so its still-high req is not regranted.
  assign elig = bus.req & ~ack_q;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_q;
    for (int k = 0; k < NUM_THREADS; k++) begin
      if (!grant_vld && elig[(int'(rr_q) + k) % NUM_THREADS]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'((int'(rr_q) + k) % NUM_THREADS);
      end
    end
  end

  assign new_val = rmw(op_q, bus.csr_out, wdata_q);
  assign wr_ok   = write_allowed(op_q, wdata_q);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    idx_d      = idx_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    caddr_rd_d = caddr_rd_q;
    caddr_wr_d = caddr_wr_q;
    cwdata_d   = cwdata_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          idx_d      = grant_idx;
          op_d       = bus.req_op[2*int'(grant_idx) +: 2];
          addr_d     = bus.req_addr[ADDR_WIDTH*int'(grant_idx) +: ADDR_WIDTH];
          wdata_d    = bus.req_wdata[DATA_WIDTH*int'(grant_idx) +: DATA_WIDTH];
          caddr_rd_d = bus.req_addr[ADDR_WIDTH*int'(grant_idx) +: ADDR_WIDTH];
          state_d    = RD;
        end
      end
      RD: begin
        caddr_wr_d = addr_q;
        state_d    = WR;
      end
      WR: begin
        cwdata_d      = new_val;
        rdata_d       = bus.csr_out;
        ack_d[idx_q]  = 1'b1;
        rr_d          = (int'(idx_q) == NUM_THREADS - 1) ? '0 : idx_q + IDX_W'(1);
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      idx_q      <= '0;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cwdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      idx_q      <= idx_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cwdata_q   <= cwdata_d;
    end
  end

  // Strobes decode from state so an asynchronous reset drops them immediately.
  assign bus.ack          = ack_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.csr_addr_out = caddr_rd_q;
  assign bus.csr_addr_in  = caddr_wr_q;
  assign bus.csr_in       = (state_q == WR) ? new_val : cwdata_q;
  assign bus.csr_wr       = (state_q == WR) && wr_ok;
  assign bus.en           = (state_q == WR) && wr_ok;

endmodule

// File: tb/tb_rv_csr_arb.sv
// Directed bench for rv_csr_arb: table of single-thread RMW vectors plus
// hand-written contention, ack-masking and mid-transaction reset sequences.
module tb_rv_csr_arb;
  localparam int NT = 4;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv_csr_arb_if #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rv_csr_arb #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  // CSR file model: 16 mapped entries, everything else reads 0xAAA.
  logic [DW-1:0] mem [0:15];
  logic          load_en = 1'b0;
  logic [3:0]    load_addr = '0;
  logic [DW-1:0] load_data = '0;

  always @(posedge clk) begin
    bus.csr_out <= (bus.csr_addr_out < AW'(16)) ? mem[bus.csr_addr_out[3:0]] : 32'hAAA;
    if (load_en)
      mem[load_addr] <= load_data;
    else if (bus.csr_wr && bus.en && (bus.csr_addr_in < AW'(16)))
      mem[bus.csr_addr_in[3:0]] <= bus.csr_in;
  end

  typedef struct {
    int           thr;
    logic [1:0]   op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    bit           pre;
    logic [DW-1:0] pre_val;
    logic [DW-1:0] exp_old;
    bit           exp_wr;
    logic [DW-1:0] exp_new;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
    bus.req_op[2*k +: 2]     = op;
    bus.req_addr[AW*k +: AW] = a;
    bus.req_wdata[DW*k +: DW] = wd;
    bus.req[k]               = 1'b1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [DW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NT-1:0] rerise;
    logic [NT-1:0] exp_ack;
    logic [12:0]   exp_busy_v;
    int            ack_cnt;
    int            busy_cnt;

    vecs[0] = '{0, 2'b01, 12'h000, 32'h0000_1234, 1'b1, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_1234};
    vecs[1] = '{1, 2'b10, 12'h000, 32'h0000_000F, 1'b1, 32'h0000_00F0, 32'h0000_00F0, 1'b1, 32'h0000_00FF};
    vecs[2] = '{1, 2'b11, 12'h000, 32'h0000_00F0, 1'b0, 32'h0,         32'h0000_00FF, 1'b1, 32'h0000_000F};
    vecs[3] = '{1, 2'b10, 12'h000, 32'h0000_0000, 1'b0, 32'h0,         32'h0000_000F, 1'b0, 32'h0};
    vecs[4] = '{2, 2'b00, 12'h300, 32'h0000_5555, 1'b0, 32'h0,         32'h0000_0AAA, 1'b0, 32'h0};
    vecs[5] = '{3, 2'b01, 12'h005, 32'hDEAD_BEEF, 1'b1, 32'h0000_0011, 32'h0000_0011, 1'b1, 32'hDEAD_BEEF};
    vecs[6] = '{3, 2'b11, 12'h005, 32'hFFFF_0000, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'h0000_BEEF};
    vecs[7] = '{0, 2'b01, 12'h005, 32'h0000_0000, 1'b0, 32'h0,         32'h0000_BEEF, 1'b1, 32'h0};

    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);

    check("rst_ack",      {28'b0, bus.ack}, 32'h0);
    check("rst_rdata",    bus.rdata, 32'h0);
    check("rst_busy",     {31'b0, bus.busy}, 32'h0);
    check("rst_addr_out", {20'b0, bus.csr_addr_out}, 32'h0);
    check("rst_addr_in",  {20'b0, bus.csr_addr_in}, 32'h0);
    check("rst_csr_in",   bus.csr_in, 32'h0);
    check("rst_csr_wr",   {31'b0, bus.csr_wr}, 32'h0);
    check("rst_en",       {31'b0, bus.en}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-thread vectors: grant at cycle 0, RD at 1, WR at 2, ack at 3.
    foreach (vecs[i]) begin
      if (vecs[i].pre) preload(vecs[i].addr[3:0], vecs[i].pre_val);
      @(negedge clk);
      set_req(vecs[i].thr, vecs[i].op, vecs[i].addr, vecs[i].wd);
      @(negedge clk);
      check("vec_rd_busy",   {31'b0, bus.busy}, 32'h1);
      check("vec_rd_addr",   {20'b0, bus.csr_addr_out}, {20'b0, vecs[i].addr});
      check("vec_rd_nowr",   {31'b0, bus.csr_wr}, 32'h0);
      @(negedge clk);
      check("vec_wr_strobe", {31'b0, bus.csr_wr}, {31'b0, vecs[i].exp_wr});
      check("vec_wr_en",     {31'b0, bus.en}, {31'b0, vecs[i].exp_wr});
      if (vecs[i].exp_wr) begin
        check("vec_wr_data", bus.csr_in, vecs[i].exp_new);
        check("vec_wr_addr", {20'b0, bus.csr_addr_in}, {20'b0, vecs[i].addr});
      end
      @(negedge clk);
      check("vec_ack",   {28'b0, bus.ack}, 32'(1) << vecs[i].thr);
      check("vec_rdata", bus.rdata, vecs[i].exp_old);
      if (vecs[i].exp_wr) check("vec_mem", mem[vecs[i].addr[3:0]], vecs[i].exp_new);
      bus.req[vecs[i].thr] = 1'b0;
    end
    wait_idle();

    // All four threads at once after reset: acks every 3 cycles in order 0..3.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NT; k++) set_req(k, 2'b00, 12'h300, 32'h0);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      exp_ack = (cyc % 3 == 0 && cyc <= 12) ? NT'(1) << (cyc / 3 - 1) : '0;
      check("rr_all_ack", {28'b0, bus.ack}, {28'b0, exp_ack});
      bus.req = bus.req & ~bus.ack;
    end
    wait_idle();

    // Threads 1 and 3 re-request the cycle after their ack: grants must alternate.
    set_req(1, 2'b00, 12'h300, 32'h0);
    set_req(3, 2'b00, 12'h300, 32'h0);
    rerise = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      exp_ack = (cyc % 3 != 0) ? 4'b0000 : (((cyc / 3) % 2) == 1) ? 4'b0010 : 4'b1000;
      check("alt_ack", {28'b0, bus.ack}, {28'b0, exp_ack});
      bus.req = bus.req | rerise;
      rerise  = bus.ack;
      bus.req = bus.req & ~bus.ack;
      if (cyc == 12) bus.req = '0;
    end
    wait_idle();

    // Thread 0 holds req one cycle past its ack: exactly one extra transaction.
    set_req(0, 2'b01, 12'h002, 32'h11);
    exp_busy_v = 13'b0000001100110;
    ack_cnt  = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      check("mask_busy", {31'b0, bus.busy}, {31'b0, exp_busy_v[cyc]});
      check("mask_ack",  {28'b0, bus.ack}, (cyc == 3 || cyc == 7) ? 32'h1 : 32'h0);
      if (bus.ack[0]) ack_cnt++;
      if (bus.busy) busy_cnt++;
      if (cyc == 5) bus.req[0] = 1'b0;
    end
    check("mask_ack_count",  ack_cnt, 2);
    check("mask_busy_count", busy_cnt, 4);
    wait_idle();

    // Reset pulled mid-WR: strobes drop at once, no ack, no write, pointer back to 0.
    preload(4'd1, 32'h99);
    @(negedge clk);
    set_req(2, 2'b01, 12'h001, 32'h77);
    @(negedge clk);
    @(negedge clk);
    check("rstwr_pre_wr", {31'b0, bus.csr_wr}, 32'h1);
    #1;
    rst_n   = 1'b0;
    bus.req = '0;
    #1;
    check("rstwr_wr",   {31'b0, bus.csr_wr}, 32'h0);
    check("rstwr_en",   {31'b0, bus.en}, 32'h0);
    check("rstwr_busy", {31'b0, bus.busy}, 32'h0);
    check("rstwr_ack",  {28'b0, bus.ack}, 32'h0);
    @(negedge clk);
    check("rstwr_ack_after", {28'b0, bus.ack}, 32'h0);
    check("rstwr_mem",       mem[1], 32'h99);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NT; k++) set_req(k, 2'b00, 12'h300, 32'h0);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      check("rstwr_first_grant", {28'b0, bus.ack}, (cyc == 3) ? 32'h1 : 32'h0);
    end
    bus.req = '0;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
